// File: rtl/cpu_mc_if.sv
// cpu_mc_if: instruction-fetch and data-memory bus of the cpu_mc core.
//   imem_addr  - instruction address (core -> memory)
//   imem_data  - 16-bit instruction word, combinational response
//   dmem_req   - data access request, held until dmem_ready
//   dmem_we    - 1 = write, 0 = read
//   dmem_addr  - data address
//   dmem_wdata - store data
//   dmem_rdata - load data, sampled when dmem_ready = 1
//   dmem_ready - access complete
// master = core side, slave = memory side.
interface cpu_mc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_addr, input imem_data,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_addr, output imem_data,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/cpu_mc.sv
// cpu_mc: parameterised multi-cycle CPU core (FETCH / EXEC / MEM / HALT).
// Ports:
//   clk         - clock, all state updates on rising edge
//   reset       - asynchronous active-low reset
//   irq         - level interrupt request (taken in FETCH/HALT when ie = 1)
//   irq_ack     - high during the cycle the interrupt is taken
//   bus         - cpu_mc_if.master: instruction fetch + data memory handshake
//   halted      - core is in HALT
//   retired_cnt - retired-instruction counter
// Optional feature macro: CPU_MC_PERF_CNT_EN enables retired_cnt;
// when undefined retired_cnt is tied to 0.
// Instruction: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
module cpu_mc #(
  parameter int         DATA_W  = 8,
  parameter int         ADDR_W  = 8,
  parameter logic [7:0] IRQ_VEC = 8'hF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  output logic        irq_ack,
  cpu_mc_if.master    bus,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6,
                         OP_SHL = 4'h7, OP_LDI = 4'h8, OP_LD  = 4'h9,
                         OP_ST  = 4'hA, OP_JMP = 4'hB, OP_JZ  = 4'hC,
                         OP_JC  = 4'hD, OP_RETI = 4'hE, OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, epc_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] regs_q [4];
  logic              z_q, c_q, ie_q;
  logic [1:0]        eflags_q;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] daddr_q;
  logic [DATA_W-1:0] wdata_q;

  // decode of the latched instruction
  logic [3:0]        op;
  logic [1:0]        rd, rs;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a;
  assign op    = ir_q[15:12];
  assign rd    = ir_q[11:10];
  assign rs    = ir_q[9:8];
  assign imm_d = DATA_W'(ir_q[7:0]);
  assign imm_a = ADDR_W'(ir_q[7:0]);

  // decode of the word being fetched: LD/ST load the dmem registers at the
  // fetch edge so the request is already on the bus during EXEC
  logic [3:0] f_op;
  logic [1:0] f_rd;
  logic       f_mem;
  assign f_op  = bus.imem_data[15:12];
  assign f_rd  = bus.imem_data[11:10];
  assign f_mem = (f_op == OP_LD) || (f_op == OP_ST);

  logic take_irq;
  assign take_irq = irq && ie_q && (state_q == S_FETCH || state_q == S_HALT);

  // ALU
  logic [DATA_W-1:0] a, b, alu_res;
  logic [DATA_W:0]   sum, diff;
  logic              alu_c, alu_op, jmp_taken;
  assign a    = regs_q[rd];
  assign b    = regs_q[rs];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_op  = 1'b1;
    case (op)
      OP_ADD:  begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];  end
      OP_SUB:  begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W]; end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~b;
      OP_SHL:  begin alu_res = {a[DATA_W-2:0], 1'b0}; alu_c = a[DATA_W-1]; end
      default: alu_op = 1'b0;
    endcase
  end

  assign jmp_taken = (op == OP_JMP) || (op == OP_JZ && z_q) || (op == OP_JC && c_q);

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (!take_irq) state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LD, OP_ST: state_d = S_MEM;
          OP_HALT:      state_d = S_HALT;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM:   if (bus.dmem_ready) state_d = S_FETCH;
      S_HALT:  if (take_irq) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq_ack        = take_irq;
    halted         = (state_q == S_HALT);
    bus.imem_addr  = pc_q;
    bus.dmem_req   = req_q;
    bus.dmem_we    = we_q;
    bus.dmem_addr  = daddr_q;
    bus.dmem_wdata = wdata_q;
  end

  // datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      epc_q    <= '0;
      ir_q     <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      ie_q     <= 1'b1;
      eflags_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      daddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        S_FETCH, S_HALT: begin
          if (take_irq) begin
            // in HALT pc already points past the HALT instruction
            epc_q    <= pc_q;
            eflags_q <= {z_q, c_q};
            pc_q     <= ADDR_W'(IRQ_VEC);
            ie_q     <= 1'b0;
          end else if (state_q == S_FETCH) begin
            ir_q <= bus.imem_data;
            pc_q <= pc_q + 1'b1;
            if (f_mem) begin
              req_q   <= 1'b1;
              we_q    <= (f_op == OP_ST);
              daddr_q <= ADDR_W'(bus.imem_data[7:0]);
              wdata_q <= regs_q[f_rd];
            end
          end
        end
        S_EXEC: begin
          if (alu_op) begin
            regs_q[rd] <= alu_res;
            z_q        <= (alu_res == '0);
            c_q        <= alu_c;
          end else if (op == OP_LDI) begin
            regs_q[rd] <= imm_d;
          end else if (jmp_taken) begin
            pc_q <= imm_a;
          end else if (op == OP_RETI) begin
            pc_q       <= epc_q;
            {z_q, c_q} <= eflags_q;
            ie_q       <= 1'b1;
          end
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            if (!we_q) regs_q[rd] <= bus.dmem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_MC_PERF_CNT_EN
  // retire = completing edge: EXEC for everything but LD/ST, MEM on ready
  logic [31:0] cnt_q;
  logic        retire;
  assign retire = (state_q == S_EXEC && op != OP_LD && op != OP_ST) ||
                  (state_q == S_MEM && bus.dmem_ready);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 32'd1;
  end
  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
Parametrised multi-cycle CPU core; successor to the fixed 8-bit single-cycle cpu.
- Instruction fetch: 16-bit word over a combinational instruction bus.
- Data memory: separate req/ready handshake bus with split read/write data, replacing the bidirectional user-memory bus.
- Register file: internal, 4 x DATA_W.
- Adds Z/C flags, conditional jumps, HALT, and a vectored, maskable interrupt with RETI.

Parameters:
DATA_W, 8, register/ALU/data-bus width (4..32)
ADDR_W, 8, instruction and data address width (4..16)
IRQ_VEC, 8'hF0, interrupt vector address, truncated to ADDR_W

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
irq  in  1  level interrupt request
irq_ack  out  1  one-cycle pulse when the interrupt is taken
imem_addr  out  ADDR_W  instruction address (= pc)
imem_data  in  16  instruction word, valid same cycle as imem_addr
dmem_req  out  1  data access request
dmem_we  out  1  1 = write, 0 = read; valid while dmem_req = 1
dmem_addr  out  ADDR_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data; sampled when dmem_ready = 1
dmem_ready  in  1  access complete
halted  out  1  core is in the HALT state
retired_cnt  out  32  retired-instruction count (optional feature)

Behaviour:
- Instruction format:
  - [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
  - imm is zero-extended or truncated to DATA_W for data and to ADDR_W for addresses.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd = rd op rs.
  - 6 NOT: rd = ~rs.
  - 7 SHL: rd = rd << 1; C = old MSB.
  - 8 LDI: rd = imm.
  - 9 LD: rd = mem[imm].
  - A ST: mem[imm] = rd.
  - B JMP: pc = imm.
  - C JZ: jump if Z. D JC: jump if C.
  - E RETI. F HALT.
- Flags:
  - Z and C are updated only by ops 1-7; Z = (result == 0).
  - C = carry-out for ADD, borrow for SUB, MSB shifted out for SHL; 0 for AND/OR/XOR/NOT.
- FSM states: FETCH, EXEC, MEM, HALT.
- FETCH:
  - If irq && ie: epc = pc, eflags = {Z,C}, pc = IRQ_VEC, ie = 0, irq_ack = 1 for this cycle; stay in FETCH.
  - Otherwise: IR = imem_data, pc = pc + 1 (wraps modulo 2^ADDR_W), go to EXEC.
- EXEC:
  - ALU ops, LDI, jumps, NOP: complete; go to FETCH. Each instruction takes 2 cycles.
  - A jump that is not taken is a NOP.
  - LD/ST: drive dmem_req = 1, dmem_we, dmem_addr = imm, dmem_wdata = rd; go to MEM.
  - RETI: pc = epc, {Z,C} = eflags, ie = 1; go to FETCH.
  - HALT: go to HALT.
- MEM:
  - Hold dmem_req and all dmem outputs stable until the cycle dmem_ready = 1.
  - On that cycle: LD writes dmem_rdata into rd; drop req on the next edge; go to FETCH.
  - Minimum instruction time 3 cycles; no timeout.
- HALT:
  - halted = 1.
  - Leave only on irq && ie: take the interrupt exactly as in FETCH (epc = address after the HALT) and go to FETCH.
- Interrupt rules:
  - Interrupts are sampled only in FETCH/HALT, never mid-instruction.
  - No nesting: ie = 0 until RETI.
  - RETI executed outside a handler still restores epc/eflags and sets ie = 1.
  - irq held high after RETI re-enters the handler on the next FETCH.
- Reset (asynchronous, any state, including mid-MEM): state = FETCH; pc = 0; regs, Z, C, epc, eflags = 0; ie = 1; dmem_req = dmem_we = 0; irq_ack = halted = 0; retired_cnt = 0.
  - dmem_addr/dmem_wdata reset to 0.
  - A pending memory access is abandoned; no write completes after reset asserts.
- Register writes occur only on the completing edge; rd == rs reads the old value.

Optional Feature:
CPU_MC_PERF_CNT_EN:
- Defined: retired_cnt increments by 1 on the completing edge of every instruction, including NOP, not-taken jumps, RETI and HALT entry. Interrupt entry does not count. Wraps at 2^32.
- Undefined: retired_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then LDI r0,5; LDI r1,3; ADD r0,r1 -> r0 = 8, Z = 0, C = 0; each instruction takes 2 cycles.
- DATA_W = 8: LDI r0,0xFF; LDI r1,1; ADD r0,r1 -> r0 = 0, Z = 1, C = 1; JZ 0x20 -> imem_addr = 0x20 next fetch.
- ST r2,0x40 with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with addr 0x40 stable; LD r3,0x40 returning 0xA5 -> r3 = 0xA5.
- irq asserted during EXEC of the instruction at 0x10 -> irq_ack pulses in the next FETCH, imem_addr = 0xF0, Z/C preserved; RETI -> pc = 0x11, flags restored.
- HALT at 0x05 -> halted = 1, pc frozen; irq -> exit to 0xF0; RETI -> fetch at 0x06.
- reset asserted mid-MEM -> dmem_req = 0 immediately, pc = 0, retired_cnt = 0; with CPU_MC_PERF_CNT_EN, 10 retired instructions -> retired_cnt = 10.
